// File: rtl/scratch_mem_responder_if.sv
// Scratch-memory bus between the divider memory controller (master) and the
// scratch array responder (slave).
interface scratch_mem_if #(
    parameter int unsigned DATA_W = 16
);
    logic              sc_mem_rd_en;
    logic [15:0]       sc_mem_rd_addr1;
    logic [15:0]       sc_mem_rd_addr2;
    logic              sc_mem_wt_en;
    logic [15:0]       sc_mem_wt_addr;
    logic [DATA_W-1:0] sc_mem_wt_data;
    logic [DATA_W-1:0] sc_mem_rd_data1;
    logic [DATA_W-1:0] sc_mem_rd_data2;
    logic              sc_mem_rd_valid;
    logic              sc_mem_ready;
    logic              sc_mem_addr_err;
    logic [15:0]       sc_mem_wt_count;

    modport master (
        output sc_mem_rd_en, sc_mem_rd_addr1, sc_mem_rd_addr2,
        output sc_mem_wt_en, sc_mem_wt_addr, sc_mem_wt_data,
        input  sc_mem_rd_data1, sc_mem_rd_data2, sc_mem_rd_valid,
        input  sc_mem_ready, sc_mem_addr_err, sc_mem_wt_count
    );

    modport slave (
        input  sc_mem_rd_en, sc_mem_rd_addr1, sc_mem_rd_addr2,
        input  sc_mem_wt_en, sc_mem_wt_addr, sc_mem_wt_data,
        output sc_mem_rd_data1, sc_mem_rd_data2, sc_mem_rd_valid,
        output sc_mem_ready, sc_mem_addr_err, sc_mem_wt_count
    );
endinterface

// File: rtl/scratch_mem_responder.sv
// Scratch array responder: two 1-cycle-latency read ports, one write port with
// write-first bypass, and a full-array clear sweep after reset or on request.
module scratch_mem_responder #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    scratch_mem_if.slave sc
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state;
    logic [AW-1:0]     clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_valid;
    logic              ready;
    logic              addr_err;
    logic [15:0]       wt_count;

    logic              idle_c;
    logic              rd_acc_c;
    logic              wt_acc_c;
    logic              rd1_in_c;
    logic              rd2_in_c;
    logic              wt_in_c;
    logic              wt_ok_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;
    logic              mem_we_c;
    logic [AW-1:0]     mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    // Request qualification, range decode and write-first read bypass
    always_comb begin
        idle_c      = (state == ST_IDLE) && !clear;
        rd_acc_c    = idle_c && sc.sc_mem_rd_en;
        wt_acc_c    = idle_c && sc.sc_mem_wt_en;
        rd1_in_c    = 32'(sc.sc_mem_rd_addr1) < DEPTH;
        rd2_in_c    = 32'(sc.sc_mem_rd_addr2) < DEPTH;
        wt_in_c     = 32'(sc.sc_mem_wt_addr) < DEPTH;
        wt_ok_c     = wt_acc_c && wt_in_c;
        rd1_c       = '0;
        rd2_c       = '0;
        if (rd1_in_c) begin
            rd1_c = (wt_ok_c && (sc.sc_mem_wt_addr == sc.sc_mem_rd_addr1))
                  ? sc.sc_mem_wt_data : mem[sc.sc_mem_rd_addr1[AW-1:0]];
        end
        if (rd2_in_c) begin
            rd2_c = (wt_ok_c && (sc.sc_mem_wt_addr == sc.sc_mem_rd_addr2))
                  ? sc.sc_mem_wt_data : mem[sc.sc_mem_rd_addr2[AW-1:0]];
        end
        mem_we_c    = 1'b0;
        mem_waddr_c = sc.sc_mem_wt_addr[AW-1:0];
        mem_wdata_c = sc.sc_mem_wt_data;
        if (state == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = clr_ptr;
            mem_wdata_c = '0;
        end else if (wt_ok_c) begin
            mem_we_c    = 1'b1;
        end
    end

    // Array storage has no reset; the clear sweep is what zeroes it
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_valid <= 1'b0;
            ready    <= 1'b0;
            addr_err <= 1'b0;
            wt_count <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clear) begin
                        clr_ptr  <= '0;
                        wt_count <= '0;
                        addr_err <= 1'b0;
                    end else if (clr_ptr == AW'(DEPTH - 1)) begin
                        state   <= ST_IDLE;
                        ready   <= 1'b1;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state    <= ST_CLEAR;
                        ready    <= 1'b0;
                        clr_ptr  <= '0;
                        wt_count <= '0;
                        addr_err <= 1'b0;
                    end else begin
                        if (rd_acc_c) begin
                            rd_data1 <= rd1_c;
                            rd_data2 <= rd2_c;
                            rd_valid <= 1'b1;
                            if (!rd1_in_c || !rd2_in_c) begin
                                addr_err <= 1'b1;
                            end
                        end
                        if (wt_acc_c) begin
                            if (!wt_in_c) begin
                                addr_err <= 1'b1;
                            end else if (wt_count != 16'hFFFF) begin
                                wt_count <= wt_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign sc.sc_mem_rd_data1 = rd_data1;
    assign sc.sc_mem_rd_data2 = rd_data2;
    assign sc.sc_mem_rd_valid = rd_valid;
    assign sc.sc_mem_ready    = ready;
    assign sc.sc_mem_addr_err = addr_err;
    assign sc.sc_mem_wt_count = wt_count;

endmodule

// File: tb/tb_scratch_mem_responder.sv
// Bench for scratch_mem_responder: directed vector table, clear/reset
// sequences and randomized traffic against a behavioural reference model.
module tb_scratch_mem_responder;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AW     = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    scratch_mem_if #(.DATA_W(DATA_W)) sc();

    scratch_mem_responder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .sc    (sc)
    );

    typedef struct {
        logic        rd;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        wt;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        ev;
        logic        ee;
        logic [15:0] ec;
    } vec_t;

    // Reference model state: word contents, sweep cycles remaining, flags
    logic [15:0] m_mem [DEPTH];
    int          sweep_left;
    logic [15:0] m_cnt;
    logic        m_err;
    logic [15:0] m_d1;
    logic [15:0] m_d2;
    logic        m_valid;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        m_cnt      = '0;
        m_err      = 1'b0;
        m_d1       = '0;
        m_d2       = '0;
        m_valid    = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input logic rd, input logic [15:0] a1, input logic [15:0] a2,
                              input logic wt, input logic [15:0] wa, input logic [15:0] wd,
                              input logic clr);
        m_valid = 1'b0;
        if (sweep_left == 0) begin
            if (clr) begin
                sweep_left = DEPTH;
                m_cnt      = '0;
                m_err      = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else begin
                if (wt) begin
                    if (32'(wa) < DEPTH) begin
                        m_mem[wa[AW-1:0]] = wd;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (rd) begin
                    m_d1    = (32'(a1) < DEPTH) ? m_mem[a1[AW-1:0]] : 16'h0;
                    m_d2    = (32'(a2) < DEPTH) ? m_mem[a2[AW-1:0]] : 16'h0;
                    m_valid = 1'b1;
                    if (32'(a1) >= DEPTH || 32'(a2) >= DEPTH) m_err = 1'b1;
                end
            end
        end else begin
            sweep_left = clr ? DEPTH : sweep_left - 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, 32'(sc.sc_mem_ready),    32'(sweep_left == 0));
        chk({tag, ".valid"}, 32'(sc.sc_mem_rd_valid), 32'(m_valid));
        chk({tag, ".d1"},    32'(sc.sc_mem_rd_data1), 32'(m_d1));
        chk({tag, ".d2"},    32'(sc.sc_mem_rd_data2), 32'(m_d2));
        chk({tag, ".err"},   32'(sc.sc_mem_addr_err), 32'(m_err));
        chk({tag, ".cnt"},   32'(sc.sc_mem_wt_count), 32'(m_cnt));
    endtask

    // One clock: inputs are applied away from the edge, outputs sampled 1 after it
    task automatic step(input logic rd, input logic [15:0] a1, input logic [15:0] a2,
                        input logic wt, input logic [15:0] wa, input logic [15:0] wd,
                        input logic clr, input string tag);
        sc.sc_mem_rd_en    = rd;
        sc.sc_mem_rd_addr1 = a1;
        sc.sc_mem_rd_addr2 = a2;
        sc.sc_mem_wt_en    = wt;
        sc.sc_mem_wt_addr  = wa;
        sc.sc_mem_wt_data  = wd;
        clear              = clr;
        @(posedge clk);
        model_edge(rd, a1, a2, wt, wa, wd, clr);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ready"}, 32'(sc.sc_mem_ready),    32'h0);
        chk({tag, ".valid"}, 32'(sc.sc_mem_rd_valid), 32'h0);
        chk({tag, ".d1"},    32'(sc.sc_mem_rd_data1), 32'h0);
        chk({tag, ".d2"},    32'(sc.sc_mem_rd_data2), 32'h0);
        chk({tag, ".err"},   32'(sc.sc_mem_addr_err), 32'h0);
        chk({tag, ".cnt"},   32'(sc.sc_mem_wt_count), 32'h0);
    endtask

    vec_t vt [11];

    initial begin
        logic [15:0] ra1, ra2, rwa;
        int          bound;

        vt[0]  = '{1'b1, 16'd0,    16'd128, 1'b0, 16'd0,     16'h0,    16'h0,    16'h0,    1'b1, 1'b0, 16'd0};
        vt[1]  = '{1'b1, 16'd255,  16'd255, 1'b0, 16'd0,     16'h0,    16'h0,    16'h0,    1'b1, 1'b0, 16'd0};
        vt[2]  = '{1'b0, 16'd0,    16'd0,   1'b1, 16'd5,     16'h1234, 16'h0,    16'h0,    1'b0, 1'b0, 16'd1};
        vt[3]  = '{1'b1, 16'd5,    16'd6,   1'b0, 16'd0,     16'h0,    16'h1234, 16'h0,    1'b1, 1'b0, 16'd1};
        vt[4]  = '{1'b1, 16'd7,    16'd7,   1'b1, 16'd7,     16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 16'd2};
        vt[5]  = '{1'b0, 16'd0,    16'd0,   1'b0, 16'd0,     16'h0,    16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'd2};
        vt[6]  = '{1'b0, 16'd0,    16'd0,   1'b1, 16'h0100,  16'hDEAD, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 16'd2};
        vt[7]  = '{1'b1, 16'h0100, 16'd5,   1'b0, 16'd0,     16'h0,    16'h0,    16'h1234, 1'b1, 1'b1, 16'd2};
        vt[8]  = '{1'b1, 16'd6,    16'd9,   1'b1, 16'd9,     16'h5A5A, 16'h0,    16'h5A5A, 1'b1, 1'b1, 16'd3};
        vt[9]  = '{1'b1, 16'hFFFF, 16'd9,   1'b0, 16'd0,     16'h0,    16'h0,    16'h5A5A, 1'b1, 1'b1, 16'd3};
        vt[10] = '{1'b1, 16'd0,    16'd0,   1'b0, 16'd0,     16'h0,    16'h0,    16'h0,    1'b1, 1'b1, 16'd3};

        sc.sc_mem_rd_en    = 1'b0;
        sc.sc_mem_rd_addr1 = '0;
        sc.sc_mem_rd_addr2 = '0;
        sc.sc_mem_wt_en    = 1'b0;
        sc.sc_mem_wt_addr  = '0;
        sc.sc_mem_wt_data  = '0;
        model_reset();

        #12;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;

        // Sweep after reset: reads are ignored, ready rises after exactly DEPTH edges
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 16'd0, 16'd255, 1'b0, 16'h0, 16'h0, 1'b0, "sweep0");
            if (i == DEPTH - 2) chk("sweep0_not_ready", 32'(sc.sc_mem_ready), 32'h0);
            if (i == DEPTH - 1) chk("sweep0_ready",     32'(sc.sc_mem_ready), 32'h1);
        end

        for (int i = 0; i < 11; i++) begin
            step(vt[i].rd, vt[i].a1, vt[i].a2, vt[i].wt, vt[i].wa, vt[i].wd, 1'b0,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.d1", i),    32'(sc.sc_mem_rd_data1), 32'(vt[i].e1));
            chk($sformatf("vec%0d.d2", i),    32'(sc.sc_mem_rd_data2), 32'(vt[i].e2));
            chk($sformatf("vec%0d.valid", i), 32'(sc.sc_mem_rd_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d.err", i),   32'(sc.sc_mem_addr_err), 32'(vt[i].ee));
            chk($sformatf("vec%0d.cnt", i),   32'(sc.sc_mem_wt_count), 32'(vt[i].ec));
        end

        // Ten writes, then a clear: counters drop, array reads back zero
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b1, 16'(20 + i), 16'(16'h0111 * (i + 1)), 1'b0, "cw");
        end
        chk("pre_clear.cnt", 32'(sc.sc_mem_wt_count), 32'd13);
        chk("pre_clear.err", 32'(sc.sc_mem_addr_err), 32'h1);
        step(1'b1, 16'd20, 16'd21, 1'b1, 16'd30, 16'h7777, 1'b1, "clr");
        chk("clr.ready", 32'(sc.sc_mem_ready),    32'h0);
        chk("clr.cnt",   32'(sc.sc_mem_wt_count), 32'h0);
        chk("clr.err",   32'(sc.sc_mem_addr_err), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 16'd20, 16'd21, 1'b1, 16'd22, 16'h1111, 1'b0, "sweep1");
            chk("sweep1.no_valid", 32'(sc.sc_mem_rd_valid), 32'h0);
            if (i == DEPTH - 2) chk("sweep1_not_ready", 32'(sc.sc_mem_ready), 32'h0);
            if (i == DEPTH - 1) chk("sweep1_ready",     32'(sc.sc_mem_ready), 32'h1);
        end
        for (int i = 0; i < 10; i += 2) begin
            step(1'b1, 16'(20 + i), 16'(21 + i), 1'b0, 16'h0, 16'h0, 1'b0, "rdback");
            chk("rdback.d1", 32'(sc.sc_mem_rd_data1), 32'h0);
            chk("rdback.d2", 32'(sc.sc_mem_rd_data2), 32'h0);
            chk("rdback.v",  32'(sc.sc_mem_rd_valid), 32'h1);
        end
        chk("rdback.cnt", 32'(sc.sc_mem_wt_count), 32'h0);

        // Clear pulse during a sweep restarts it from the beginning
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, "clrA");
        for (int i = 0; i < 40; i++) idle("sweepA");
        step(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, "clrB");
        for (int i = 0; i < DEPTH; i++) idle("sweepB");
        chk("restart.ready", 32'(sc.sc_mem_ready), 32'h1);

        // Randomized controller-like traffic with small address sets for collisions
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(0, 99);
            ra1 = (sel < 80) ? 16'($urandom_range(0, 15)) :
                  (sel < 95) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(256, 65535));
            sel = $urandom_range(0, 99);
            ra2 = (sel < 80) ? 16'($urandom_range(0, 15)) :
                  (sel < 95) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(256, 65535));
            sel = $urandom_range(0, 99);
            rwa = (sel < 80) ? 16'($urandom_range(0, 15)) :
                  (sel < 97) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(256, 65535));
            step(1'($urandom_range(0, 1)), ra1, ra2, 1'($urandom_range(0, 1)), rwa,
                 16'($urandom), 1'($urandom_range(0, 599) == 0), "rand");
        end

        // Bring the block to IDLE, then reset in the middle of a read
        bound = 0;
        while (sweep_left != 0 && bound < 2 * DEPTH) begin
            idle("drain");
            bound++;
        end
        chk("drain.bound", 32'(sweep_left == 0), 32'h1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 16'd3, 16'hA5A5, 1'b0, "wr3");
        step(1'b1, 16'd3, 16'd3, 1'b0, 16'h0, 16'h0, 1'b0, "rd3");
        chk("rd3.d1", 32'(sc.sc_mem_rd_data1), 32'hA5A5);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("rst_mid_read");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) idle("sweepC");

        // Reset in the middle of a sweep
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("rst_mid_sweep");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle("sweepD");
            if (i == DEPTH - 2) chk("sweepD_not_ready", 32'(sc.sc_mem_ready), 32'h0);
        end
        step(1'b1, 16'd3, 16'd128, 1'b0, 16'h0, 16'h0, 1'b0, "rd3_after");
        chk("rd3_after.d1", 32'(sc.sc_mem_rd_data1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scratch_mem_responder.md
Name: scratch_mem_responder

Overview:
Responder side of the scratch-memory interface driven by the divider memory controller. It holds the CDF/result scratch array and services two read ports and one write port. It returns read data with fixed one-cycle latency and reports readiness, address errors and write progress. After reset, and on request, it runs an internal clear sweep that zeroes the whole array.

Parameters:
DEPTH, 256, number of scratch words (power of two, at most 65536)
DATA_W, 16, width of each scratch word
AW, 8, log2(DEPTH); the address bits actually decoded

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  single-cycle pulse; starts a clear sweep
sc_mem_rd_en  input  1  read request for both read ports
sc_mem_rd_addr1  input  16  read port 1 address
sc_mem_rd_addr2  input  16  read port 2 address
sc_mem_wt_en  input  1  write request
sc_mem_wt_addr  input  16  write address
sc_mem_wt_data  input  DATA_W  write data
sc_mem_rd_data1  output  DATA_W  read port 1 data
sc_mem_rd_data2  output  DATA_W  read port 2 data
sc_mem_rd_valid  output  1  one-cycle pulse; both rd_data outputs are valid
sc_mem_ready  output  1  high in IDLE; requests are accepted only while high
sc_mem_addr_err  output  1  sticky flag for an out-of-range access
sc_mem_wt_count  output  16  number of accepted writes since the last clear

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters CLEAR with clr_ptr=0.
  - rd_data1/2=0, rd_valid=0, ready=0, addr_err=0, wt_count=0.
  - Array contents are not reset directly; the clear sweep zeroes them.
- FSM states:
  - CLEAR: writes 0 to array[clr_ptr] each cycle and increments clr_ptr. When clr_ptr==DEPTH-1 is written, the next state is IDLE. The sweep takes exactly DEPTH cycles.
  - IDLE: ready=1; reads and writes are serviced.
  - A clear pulse in IDLE: next state CLEAR, clr_ptr=0, wt_count=0, addr_err=0. A read or write request in that same cycle is ignored.
  - A clear pulse while already in CLEAR restarts the sweep at clr_ptr=0.
- Requests arriving while ready=0 are dropped silently: no rd_valid, no write, no count, no error.
- Address range:
  - An address is in range when addr < DEPTH; the upper bits must be zero.
  - A read of an out-of-range address returns 0 on that port and sets addr_err.
  - A write to an out-of-range address is dropped, sets addr_err, and does not increment wt_count.
  - addr_err clears only on reset or clear.
- Read (IDLE, rd_en=1, sampled at edge N):
  - rd_data1 = array[addr1] and rd_data2 = array[addr2] are registered at edge N.
  - rd_valid=1 for exactly the cycle after edge N. Latency is 1 cycle.
  - rd_en held high gives a new result every cycle.
  - rd_data holds its last value when rd_valid=0.
  - addr1==addr2 is legal; both ports return the same word.
- Write (IDLE, wt_en=1, in range): array[wt_addr] = wt_data at the edge. wt_count increments by 1 and saturates at 16'hFFFF.
- Simultaneous read and write of the same address in the same cycle is write-first: the read port returns the new wt_data (bypass). This applies to each port independently.
- Simultaneous read and write of different addresses: both complete in the same cycle.
- A reset asserted mid-sweep or mid-read aborts immediately to the reset values above. The sweep restarts after reset deasserts.

Test Plan:
- Reset release with DEPTH=256: ready stays 0 for exactly 256 cycles, then goes 1. Reads of addresses 0, 128 and 255 return 0 with rd_valid one cycle after rd_en.
- Write 16'h1234 to addr 5, then on the next cycle read addr1=5, addr2=6: rd_data1=16'h1234, rd_data2=0, rd_valid pulses once, wt_count=1.
- Same cycle: wt_en to addr 7 with data 16'hBEEF, plus rd_en with addr1=7, addr2=7 -> both ports return 16'hBEEF (bypass).
- Out-of-range access:
  - Write to addr 16'h0100 with DEPTH=256: array unchanged, addr_err=1, wt_count unchanged.
  - Read of addr 16'h0100: returns 0.
  - addr_err stays 1 until clear.
- Pulse clear after 10 writes: ready drops for 256 cycles, wt_count=0, addr_err=0, all previously written words read back as 0. An rd_en issued during CLEAR produces no rd_valid.
- Drive the divider memory controller against this block with div_done toggling every 10 time units: every controller read gets exactly one rd_valid. The final wt_count equals the number of wt_en pulses issued while ready=1.
